// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : default 640x480 raster timing, colour layout and palette defaults
// Revision: 1.0
// ============================================================================
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int R_LSB = 0;
    localparam int G_LSB = 4;
    localparam int B_LSB = 8;

    localparam logic [11:0] PAL_RESET_ENTRY0 = 12'h000;
    localparam logic [11:0] PAL_RESET_OTHERS = 12'hFFF;

    typedef logic [11:0] color_t;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic frame;
        logic line;
    } raster_flags_t;

    function automatic color_t pal_reset_value(input int idx);
        return (idx == 0) ? PAL_RESET_ENTRY0 : PAL_RESET_OTHERS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// vga_timing_gen : h/v raster counters plus raw active/sync/pulse flags
// Revision: 1.0
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int SYNC_ACTIVE_LOW = 1,
    localparam int H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL        = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW             = $clog2(H_TOTAL),
    localparam int VW             = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          resetn,
    output logic [HW-1:0] h_count,
    output logic [VW-1:0] v_count,
    output raster_flags_t flags
);

    localparam logic SYNC_ON = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [31:0]   h32, v32;

    assign h32 = 32'(h_q);
    assign v32 = 32'(v_q);

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h32 == H_TOTAL - 1) begin
            h_d = '0;
            v_d = (v32 == V_TOTAL - 1) ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        flags.active = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
        flags.hsync  = ((h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC))
                       ? SYNC_ON : ~SYNC_ON;
        flags.vsync  = ((v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC))
                       ? SYNC_ON : ~SYNC_ON;
        flags.frame  = (h32 == 0) && (v32 == 0);
        flags.line   = (h32 == 0);
    end

    assign h_count = h_q;
    assign v_count = v_q;

endmodule
`default_nettype wire

// File: rtl/vga_scaled_renderer.sv
`default_nettype none
// ============================================================================
// vga_scaled_renderer : scaled framebuffer fetch, double-buffered palette, VGA out
// Revision: 1.0
// ============================================================================
module vga_scaled_renderer
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter int SCALE           = 2,
    parameter int PIXEL_BITS      = 2,
    parameter int RD_LATENCY      = 1,
    parameter int SYNC_ACTIVE_LOW = 1,
    localparam int FB_W           = H_ACTIVE / SCALE,
    localparam int FB_H           = V_ACTIVE / SCALE,
    localparam int AW             = $clog2(FB_W * FB_H),
    localparam int L              = RD_LATENCY + 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [PIXEL_BITS-1:0] pixel_data,
    input  logic                  palette_we,
    input  logic [PIXEL_BITS-1:0] palette_waddr,
    input  logic [11:0]           palette_wdata,
    output logic                  fb_rd_en,
    output logic [AW-1:0]         fb_addr,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  data_enable,
    output logic                  frame_pulse,
    output logic                  line_pulse
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PAL_N   = 2 ** PIXEL_BITS;
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam raster_flags_t FLAGS_IDLE = '{active: 1'b0, hsync: SYNC_IDLE,
                                             vsync: SYNC_IDLE, frame: 1'b0, line: 1'b0};

    if (SCALE < 1) begin : g_bad_scale_min
        $error("SCALE must be at least 1");
    end else if (((H_ACTIVE % SCALE) != 0) || ((V_ACTIVE % SCALE) != 0)) begin : g_bad_scale_div
        $error("SCALE must divide H_ACTIVE and V_ACTIVE");
    end
    if (V_FP + V_SYNC + V_BP < 2) begin : g_bad_vblank
        $error("vertical blanking must be at least two lines");
    end
    if (RD_LATENCY < 1) begin : g_bad_latency
        $error("RD_LATENCY must be at least 1");
    end

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    raster_flags_t raw_flags;
    logic [31:0]   h32, v32;

    vga_timing_gen #(
        .H_ACTIVE        (H_ACTIVE),
        .H_FP            (H_FP),
        .H_SYNC          (H_SYNC),
        .H_BP            (H_BP),
        .V_ACTIVE        (V_ACTIVE),
        .V_FP            (V_FP),
        .V_SYNC          (V_SYNC),
        .V_BP            (V_BP),
        .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
    ) u_timing (
        .clk     (clk),
        .resetn  (resetn),
        .h_count (h_count),
        .v_count (v_count),
        .flags   (raw_flags)
    );

    assign h32 = 32'(h_count);
    assign v32 = 32'(v_count);

    logic [SW-1:0] sx_sub_q, sx_sub_d;
    logic [SW-1:0] sy_sub_q, sy_sub_d;
    logic [AW-1:0] fb_x_q, fb_x_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          fb_rd_en_q, fb_rd_en_d;
    logic [AW-1:0] fb_addr_q, fb_addr_d;
    color_t        rgb_q, rgb_d;
    raster_flags_t flags_q [L];
    raster_flags_t flags_d [L];
    color_t        pal_shadow_q [PAL_N];
    color_t        pal_shadow_d [PAL_N];
    color_t        pal_active_q [PAL_N];
    color_t        pal_active_d [PAL_N];

    logic h_last, v_last, v_in_active, copy_now;

    assign h_last      = (h32 == H_TOTAL - 1);
    assign v_last      = (v32 == V_TOTAL - 1);
    assign v_in_active = (v32 < V_ACTIVE);
    // One line past the last active row the output pipeline is guaranteed empty
    assign copy_now    = (h32 == 0) && (v32 == V_ACTIVE + 1);

    // Replication sub-counters track the current (h,v) so the address needs no divide
    always_comb begin
        sx_sub_d   = sx_sub_q;
        fb_x_d     = fb_x_q;
        sy_sub_d   = sy_sub_q;
        row_base_d = row_base_q;
        if (h_last) begin
            sx_sub_d = '0;
            fb_x_d   = '0;
            if (v_last) begin
                sy_sub_d   = '0;
                row_base_d = '0;
            end else if (v_in_active) begin
                if (sy_sub_q == SW'(SCALE - 1)) begin
                    sy_sub_d   = '0;
                    row_base_d = row_base_q + AW'(FB_W);
                end else begin
                    sy_sub_d = sy_sub_q + 1'b1;
                end
            end
        end else if (sx_sub_q == SW'(SCALE - 1)) begin
            sx_sub_d = '0;
            fb_x_d   = fb_x_q + 1'b1;
        end else begin
            sx_sub_d = sx_sub_q + 1'b1;
        end
    end

    always_comb begin
        fb_rd_en_d = raw_flags.active;
        fb_addr_d  = raw_flags.active ? (row_base_q + fb_x_q) : fb_addr_q;
    end

    always_comb begin
        flags_d[0] = raw_flags;
        for (int i = 1; i < L; i++) begin
            flags_d[i] = flags_q[i-1];
        end
    end

    // Copy reads the pre-write shadow, so a write on the copy cycle waits a frame
    always_comb begin
        pal_shadow_d = pal_shadow_q;
        pal_active_d = pal_active_q;
        if (copy_now) begin
            pal_active_d = pal_shadow_q;
        end
        if (palette_we) begin
            pal_shadow_d[palette_waddr] = palette_wdata;
        end
    end

    always_comb begin
        rgb_d = '0;
        if (flags_q[L-2].active) begin
            rgb_d = pal_active_q[pixel_data];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sx_sub_q   <= '0;
            sy_sub_q   <= '0;
            fb_x_q     <= '0;
            row_base_q <= '0;
            fb_rd_en_q <= 1'b0;
            fb_addr_q  <= '0;
            rgb_q      <= '0;
            for (int i = 0; i < L; i++) begin
                flags_q[i] <= FLAGS_IDLE;
            end
            for (int i = 0; i < PAL_N; i++) begin
                pal_shadow_q[i] <= pal_reset_value(i);
                pal_active_q[i] <= pal_reset_value(i);
            end
        end else begin
            sx_sub_q     <= sx_sub_d;
            sy_sub_q     <= sy_sub_d;
            fb_x_q       <= fb_x_d;
            row_base_q   <= row_base_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_addr_q    <= fb_addr_d;
            rgb_q        <= rgb_d;
            flags_q      <= flags_d;
            pal_shadow_q <= pal_shadow_d;
            pal_active_q <= pal_active_d;
        end
    end

    assign fb_rd_en    = fb_rd_en_q;
    assign fb_addr     = fb_addr_q;
    assign red         = rgb_q[R_LSB +: 4];
    assign green       = rgb_q[G_LSB +: 4];
    assign blue        = rgb_q[B_LSB +: 4];
    assign hsync       = flags_q[L-1].hsync;
    assign vsync       = flags_q[L-1].vsync;
    assign data_enable = flags_q[L-1].active;
    assign frame_pulse = flags_q[L-1].frame;
    assign line_pulse  = flags_q[L-1].line;

endmodule
`default_nettype wire

// File: tb/tb_vga_scaled_renderer.sv
`default_nettype none
// ============================================================================
// tb_vga_scaled_renderer : directed bench on a reduced 16x8 raster, SCALE 2, RD_LATENCY 3
// Revision: 1.0
// ============================================================================
module tb_vga_scaled_renderer;

    localparam int HT    = 24;     // 16 + 2 + 3 + 3
    localparam int VT    = 12;     // 8 + 1 + 2 + 1
    localparam int LAT   = 5;      // RD_LATENCY + 2
    localparam int FB_W  = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [1:0] pixel_data;
    logic       palette_we = 1'b0;
    logic [1:0] palette_waddr = '0;
    logic [11:0] palette_wdata = '0;
    logic       fb_rd_en;
    logic [4:0] fb_addr;
    logic [3:0] red, green, blue;
    logic       hsync, vsync, data_enable, frame_pulse, line_pulse;

    always #5 clk = ~clk;

    vga_scaled_renderer #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SCALE(2), .PIXEL_BITS(2), .RD_LATENCY(3), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .resetn(resetn), .pixel_data(pixel_data),
        .palette_we(palette_we), .palette_waddr(palette_waddr), .palette_wdata(palette_wdata),
        .fb_rd_en(fb_rd_en), .fb_addr(fb_addr),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .data_enable(data_enable),
        .frame_pulse(frame_pulse), .line_pulse(line_pulse)
    );

    // Framebuffer model: synchronous read, three-cycle latency
    logic [1:0] fb_mem [32];
    logic [1:0] rd_pipe [3];
    logic       force_11 = 1'b0;

    always @(posedge clk) begin
        if (fb_rd_en) rd_pipe[0] <= fb_mem[fb_addr];
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end
    assign pixel_data = force_11 ? 2'b11 : rd_pipe[2];

    int total = 0;
    int bad = 0;
    int k = 0;
    int fp_count = 0;
    int exp_addr = 0;
    bit force_on = 1'b0;
    int force_start = 0;
    logic [11:0] exp_act [4];
    logic [11:0] exp_shd [4];
    bit          pend_we = 1'b0;
    logic [1:0]  pend_addr = '0;
    logic [11:0] pend_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic bit is_act(input int s);
        return (s >= 0) && ((s % HT) < 16) && (((s / HT) % VT) < 8);
    endfunction

    function automatic int faddr(input int s);
        return (((s / HT) % VT) / 2) * FB_W + (s % HT) / 2;
    endfunction

    task automatic model_reset();
        k = 0;
        exp_addr = 0;
        pend_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_act[i] = (i == 0) ? 12'h000 : 12'hFFF;
            exp_shd[i] = exp_act[i];
        end
    endtask

    task automatic check_reset();
        chk("rst_rd_en", fb_rd_en, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_rgb", {blue, green, red}, 0);
        chk("rst_de", data_enable, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_frame", frame_pulse, 0);
        chk("rst_line", line_pulse, 0);
    endtask

    task automatic check_pins();
        int s, s1, h, v, idx;
        bit act, hs, vs, fr, ln, rd;
        logic [11:0] rgb;
        s = k - LAT;
        s1 = k - 1;
        act = 1'b0; hs = 1'b1; vs = 1'b1; fr = 1'b0; ln = 1'b0; rgb = '0;
        if (s >= 0) begin
            h = s % HT;
            v = (s / HT) % VT;
            act = (h < 16) && (v < 8);
            hs = !((h >= 18) && (h < 21));
            vs = !((v >= 9) && (v < 11));
            fr = (h == 0) && (v == 0);
            ln = (h == 0);
            if (act) begin
                idx = (force_on && s >= force_start) ? 3 : int'(fb_mem[faddr(s)]);
                rgb = exp_act[idx];
            end
        end
        rd = is_act(s1);
        if (rd) exp_addr = faddr(s1);
        if (frame_pulse) fp_count++;
        chk("de", data_enable, act);
        chk("hsync", hsync, hs);
        chk("vsync", vsync, vs);
        chk("frame", frame_pulse, fr);
        chk("line", line_pulse, ln);
        chk("rgb", {blue, green, red}, rgb);
        chk("rd_en", fb_rd_en, rd);
        chk("addr", fb_addr, exp_addr);
    endtask

    task automatic drive();
        if ((k % HT) == 0 && ((k / HT) % VT) == 9) exp_act = exp_shd;
        if (pend_we) begin
            palette_we = 1'b1;
            palette_waddr = pend_addr;
            palette_wdata = pend_data;
            exp_shd[pend_addr] = pend_data;
            pend_we = 1'b0;
        end else begin
            palette_we = 1'b0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            check_pins();
            drive();
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) fb_mem[i] = 2'((i + 1) % 4);
        for (int i = 0; i < 3; i++) rd_pipe[i] = 2'b00;
        repeat (3) @(negedge clk);
        check_reset();
        resetn = 1'b1;
        model_reset();

        // First pixel (0,0): index 1 with default palette
        run(5);
        chk("px00_de", data_enable, 1);
        chk("px00_rgb", {blue, green, red}, 12'hFFF);
        chk("px00_frame", frame_pulse, 1);

        // Mid-frame shadow write of entry 1 -> green, visible next frame
        run(48);
        pend_we = 1'b1; pend_addr = 2'd1; pend_data = 12'h0F0;
        run(131);
        chk("last_addr", fb_addr, 31);
        chk("last_rd_en", fb_rd_en, 1);
        run(109);
        chk("f1_red", red, 0);
        chk("f1_green", green, 4'hF);
        chk("f1_blue", blue, 0);

        // Write on frame 1 copy cycle (h=0, v=9): reaches screen in frame 3
        run(211);
        pend_we = 1'b1; pend_addr = 2'd2; pend_data = 12'h00F;
        run(648);
        chk("frame_count", fp_count, 4);

        // Force index 3 everywhere: blanking must still be black
        force_11 = 1'b1;
        force_on = 1'b1;
        force_start = k;
        run(365);
        chk("pre_rst_de", data_enable, 1);
        chk("pre_rst_red", red, 4'hF);

        // Asynchronous reset mid-frame
        #2 resetn = 1'b0;
        #1 check_reset();
        @(negedge clk);
        @(negedge clk);
        force_11 = 1'b0;
        force_on = 1'b0;
        resetn = 1'b1;
        model_reset();
        run(5);
        chk("post_rst_rgb", {blue, green, red}, 12'hFFF);
        chk("post_rst_frame", frame_pulse, 1);
        run(293);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
